instruction_fetch: RTL and testbench

- Front end of the MIPS core, on the read side of the instruction memory.
- Holds the PC and drives the memory's 10-bit address. Captures the 32-bit instruction word into an instruction register (IR) for decode.
- Resolves unconditional jumps locally and applies branch redirects from the datapath.
- Selects the program entry point (fibonacci / fatorial / sintetico / spare) on a start pulse.

---
 rtl/instruction_fetch.sv | 152 +++++++++++++++
 tb/tb_instruction_fetch.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, drives the instruction memory
// address, captures fetched words into the instruction register, resolves
// absolute jumps locally and applies branch redirects from the datapath.
module instruction_fetch #(
   parameter logic [9:0]  START0    = 10'd1,        // fibonacci
   parameter logic [9:0]  START1    = 10'd15,       // fatorial
   parameter logic [9:0]  START2    = 10'd30,       // sintetico
   parameter logic [9:0]  START3    = 10'd40,       // spare
   parameter int unsigned LOAD_WAIT = 2,            // memory init cycles before first fetch (>= 1)
   parameter logic [5:0]  JUMP_OP   = 6'b010000
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   input  logic [1:0]  prog_sel,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [9:0]  branch_target,
   output logic [9:0]  address,
   input  logic [31:0] instrucao,
   output logic [31:0] ir,
   output logic        ir_valid,
   output logic [9:0]  pc_ir,
   output logic        running,
   output logic        halted,
   output logic [15:0] instr_count
);

   // Wait counter runs 0 .. LOAD_WAIT-1; a LOAD_WAIT of 0 behaves as 1.
   localparam int unsigned     WAIT_W    = (LOAD_WAIT > 2) ? $clog2(LOAD_WAIT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST =
      (LOAD_WAIT > 0) ? WAIT_W'(LOAD_WAIT - 1) : '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_FETCH = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [9:0]          pc_q, pc_d;
   logic [31:0]         ir_q, ir_d;
   logic                ir_valid_q, ir_valid_d;
   logic [9:0]          pc_ir_q, pc_ir_d;
   logic [15:0]         instr_count_q, instr_count_d;
   logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
   logic [9:0]          start_pc;

   // Entry point for the program selected on the start pulse.
   always_comb begin
      start_pc = START0;
      case (prog_sel)
         2'd0:    start_pc = START0;
         2'd1:    start_pc = START1;
         2'd2:    start_pc = START2;
         default: start_pc = START3;
      endcase
   end

   // Next-state logic: start handling, load wait, and the fetch priority chain.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      ir_d          = ir_q;
      ir_valid_d    = ir_valid_q;
      pc_ir_d       = pc_ir_q;
      instr_count_d = instr_count_q;
      wait_cnt_d    = wait_cnt_q;

      case (state_q)
         S_IDLE, S_HALT: begin
            // start wins over any stall/branch presented at the same time
            if (start) begin
               pc_d          = start_pc;
               ir_valid_d    = 1'b0;
               instr_count_d = '0;
               wait_cnt_d    = '0;
               state_d       = S_WAIT;
            end
         end

         S_WAIT: begin
            ir_valid_d = 1'b0;
            if (wait_cnt_q == WAIT_LAST) begin
               state_d = S_FETCH;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end

         S_FETCH: begin
            if (branch_taken) begin
               // word on instrucao this cycle is wrong-path: squash it
               pc_d       = branch_target;
               ir_valid_d = 1'b0;
            end else if (stall) begin
               // everything held
            end else if (instrucao == 32'h0000_0000) begin
               // zero word marks end of program; PC stays on it
               ir_valid_d = 1'b0;
               state_d    = S_HALT;
            end else begin
               ir_d       = instrucao;
               pc_ir_d    = pc_q;
               ir_valid_d = 1'b1;
               if (instr_count_q != 16'hFFFF) begin
                  instr_count_d = instr_count_q + 16'd1;
               end
               // X words fail this compare in simulation and fall to sequential
               if (instrucao[31:26] == JUMP_OP) begin
                  pc_d = instrucao[9:0];
               end else begin
                  pc_d = pc_q + 10'd1;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with asynchronous active-low reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         pc_q          <= '0;
         ir_q          <= '0;
         ir_valid_q    <= 1'b0;
         pc_ir_q       <= '0;
         instr_count_q <= '0;
         wait_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         ir_q          <= ir_d;
         ir_valid_q    <= ir_valid_d;
         pc_ir_q       <= pc_ir_d;
         instr_count_q <= instr_count_d;
         wait_cnt_q    <= wait_cnt_d;
      end
   end

   assign address     = pc_q;
   assign ir          = ir_q;
   assign ir_valid    = ir_valid_q;
   assign pc_ir       = pc_ir_q;
   assign instr_count = instr_count_q;
   assign running     = (state_q == S_WAIT) || (state_q == S_FETCH);
   assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: directed scenarios plus a randomized run,
// every cycle compared against a program-level reference model.
module tb_instruction_fetch;

   localparam int       LOAD_WAIT = 2;
   localparam logic [5:0] JUMP_OP = 6'b010000;

   localparam int M_IDLE = 0;
   localparam int M_WAIT = 1;
   localparam int M_RUN  = 2;
   localparam int M_HALT = 3;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  prog_sel;
   logic        stall;
   logic        branch_taken;
   logic [9:0]  branch_target;
   logic [9:0]  address;
   logic [31:0] instrucao;
   logic [31:0] ir;
   logic        ir_valid;
   logic [9:0]  pc_ir;
   logic        running;
   logic        halted;
   logic [15:0] instr_count;

   logic [31:0] mem [0:1023];

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   // reference model state
   int          m_mode;
   int          m_wait_left;
   int          m_pc;
   logic [31:0] m_ir;
   logic        m_valid;
   int          m_pcir;
   int          m_count;
   int          entry [4] = '{1, 15, 30, 40};

   instruction_fetch dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .start         (start),
      .prog_sel      (prog_sel),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .address       (address),
      .instrucao     (instrucao),
      .ir            (ir),
      .ir_valid      (ir_valid),
      .pc_ir         (pc_ir),
      .running       (running),
      .halted        (halted),
      .instr_count   (instr_count)
   );

   always #5 clock = ~clock;

   assign instrucao = mem[address];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_wait_left = 0; m_pc = 0;
      m_ir = '0; m_valid = 1'b0; m_pcir = 0; m_count = 0;
   endtask

   // One clock edge of program-level behaviour, using the inputs in force.
   task automatic model_edge();
      logic [31:0] w;
      if (m_mode == M_IDLE || m_mode == M_HALT) begin
         if (start) begin
            m_pc = entry[prog_sel]; m_valid = 1'b0; m_count = 0;
            m_wait_left = LOAD_WAIT; m_mode = M_WAIT;
         end
      end else if (m_mode == M_WAIT) begin
         m_wait_left--;
         if (m_wait_left <= 0) m_mode = M_RUN;
      end else begin
         if (branch_taken) begin
            m_pc = int'(branch_target); m_valid = 1'b0;
         end else if (!stall) begin
            w = mem[m_pc];
            if (w == 32'h0) begin
               m_mode = M_HALT; m_valid = 1'b0;
            end else begin
               m_ir = w; m_pcir = m_pc; m_valid = 1'b1;
               if (m_count < 65535) m_count++;
               if (w[31:26] == JUMP_OP) m_pc = int'(w[9:0]);
               else m_pc = (m_pc + 1) % 1024;
            end
         end
      end
   endtask

   task automatic check_all();
      chk("address", 32'(address), 32'(m_pc));
      chk("ir", ir, m_ir);
      chk("ir_valid", 32'(ir_valid), 32'(m_valid));
      chk("pc_ir", 32'(pc_ir), 32'(m_pcir));
      chk("running", 32'(running), 32'(m_mode == M_WAIT || m_mode == M_RUN));
      chk("halted", 32'(halted), 32'(m_mode == M_HALT));
      chk("instr_count", 32'(instr_count), 32'(m_count));
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic pulse_start(input logic [1:0] sel);
      start = 1'b1; prog_sel = sel;
      step();
      start = 1'b0;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic async_reset();
      #2 reset_n = 1'b0;
      #1 model_reset();
      check_all();
      #1 reset_n = 1'b1;
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w[31:26] == JUMP_OP) w[31:26] = ~JUMP_OP;
      if (w == 32'h0) w = 32'h1;
      return w;
   endfunction

   function automatic logic [31:0] jump_word(input int target);
      logic [15:0] mid;
      mid = 16'($urandom);
      return {JUMP_OP, mid, 10'(target)};
   endfunction

   task automatic clear_mem();
      for (int a = 0; a < 1024; a++) mem[a] = 32'h0;
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; prog_sel = 2'd0; stall = 1'b0;
      branch_taken = 1'b0; branch_target = '0;
      clear_mem();
      model_reset();

      // reset state
      #2;
      check_all();
      #4 reset_n = 1'b1;
      step(); step();

      // fibonacci: 1..11, jump at 11 back to 6
      for (int a = 1; a <= 10; a++) mem[a] = rand_word();
      mem[11] = jump_word(6);
      pulse_start(2'd0);
      step(); step();
      chk("first_fetch_addr", 32'(address), 32'd1);
      chk("first_fetch_valid", 32'(ir_valid), 32'd0);
      for (int i = 0; i < 11; i++) step();
      chk("after_jump_addr", 32'(address), 32'd6);
      chk("jump_issued_pcir", 32'(pc_ir), 32'd11);
      for (int i = 0; i < 8; i++) step();

      // fatorial with branch redirect while ir holds 22
      async_reset();
      clear_mem();
      for (int a = 15; a <= 40; a++) mem[a] = rand_word();
      for (int a = 61; a <= 80; a++) mem[a] = rand_word();
      pulse_start(2'd1);
      begin
         bit found = 1'b0;
         for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (m_valid && m_pcir == 22) found = 1'b1;
         end
         chk("reach_pc22", 32'(found), 32'd1);
      end
      branch_taken = 1'b1; branch_target = 10'd61;
      step();
      branch_taken = 1'b0;
      chk("branch_addr", 32'(address), 32'd61);
      chk("branch_bubble", 32'(ir_valid), 32'd0);
      step();
      chk("branch_pcir", 32'(pc_ir), 32'd61);
      chk("branch_ir", ir, mem[61]);
      step(); step();

      // stall for 3 cycles, then stall together with branch
      stall = 1'b1;
      step(); step(); step();
      branch_taken = 1'b1; branch_target = 10'd70;
      step();
      chk("stall_branch_addr", 32'(address), 32'd70);
      chk("stall_branch_valid", 32'(ir_valid), 32'd0);
      stall = 1'b0; branch_taken = 1'b0;
      step(); step();

      // sintetico halting on a zero word at 36, then spare
      async_reset();
      clear_mem();
      for (int a = 30; a <= 35; a++) mem[a] = rand_word();
      for (int a = 40; a <= 50; a++) mem[a] = rand_word();
      for (int a = 1020; a <= 1023; a++) mem[a] = rand_word();
      for (int a = 0; a <= 5; a++) mem[a] = rand_word();
      stall = 1'b1; branch_taken = 1'b1; branch_target = 10'd99;
      pulse_start(2'd2);
      stall = 1'b0; branch_taken = 1'b0;
      for (int i = 0; i < 12; i++) step();
      chk("halt_count", 32'(instr_count), 32'd6);
      chk("halt_flag", 32'(halted), 32'd1);
      chk("halt_valid", 32'(ir_valid), 32'd0);
      chk("halt_pcir", 32'(pc_ir), 32'd35);
      pulse_start(2'd3);
      chk("spare_addr", 32'(address), 32'd40);
      chk("spare_count", 32'(instr_count), 32'd0);
      step(); step(); step(); step();

      // PC wrap from 1020, with an ignored start during FETCH
      branch_taken = 1'b1; branch_target = 10'd1020;
      step();
      branch_taken = 1'b0;
      step(); step();
      start = 1'b1; prog_sel = 2'd2;
      step();
      start = 1'b0;
      step();
      chk("wrap_addr", 32'(address), 32'd0);
      step();
      chk("wrap_pcir", 32'(pc_ir), 32'd0);
      step(); step();

      // async reset mid-FETCH, then idle until start
      async_reset();
      chk("rst_addr", 32'(address), 32'd0);
      chk("rst_count", 32'(instr_count), 32'd0);
      for (int i = 0; i < 3; i++) step();

      // randomized run over a 128-word region
      clear_mem();
      for (int a = 0; a < 128; a++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 3) mem[a] = 32'h0;
         else if (r < 11) mem[a] = jump_word($urandom_range(0, 127));
         else mem[a] = rand_word();
      end
      for (int i = 0; i < 400; i++) begin
         stall         = ($urandom_range(0, 9) == 0);
         branch_taken  = ($urandom_range(0, 19) == 0);
         branch_target = 10'($urandom_range(0, 127));
         prog_sel      = 2'($urandom_range(0, 3));
         start         = (m_mode == M_IDLE || m_mode == M_HALT) ? 1'b1
                         : ($urandom_range(0, 29) == 0);
         step();
      end
      start = 1'b0; stall = 1'b0; branch_taken = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
